// File: rtl/apple1_reset_pkg.sv
// Shared state and reset-cause encodings for the Apple-1 reset sequencer.
`default_nettype none

package apple1_reset_pkg;

    localparam logic [1:0] HOLD         = 2'd0;
    localparam logic [1:0] WAIT_RELEASE = 2'd1;
    localparam logic [1:0] RUN          = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD = HOLD,
        ST_WAIT = WAIT_RELEASE,
        ST_RUN  = RUN
    } state_e;

    localparam logic [1:0] CAUSE_POR   = 2'b00;
    localparam logic [1:0] CAUSE_KEY   = 2'b01;
    localparam logic [1:0] CAUSE_BREAK = 2'b10;

endpackage

`default_nettype wire

// File: rtl/apple1_reset_ctrl_if.sv
// Board-side pins of the reset sequencer: raw inputs in, core-facing reset/RXD out.
`default_nettype none

interface apple1_reset_ctrl_if;
    logic       key_n;
    logic       uart_rxd_raw;
    logic       uart_rxd;
    logic       rst_n_out;
    logic [1:0] reset_cause;
    logic       break_active;

    modport master (
        output key_n, uart_rxd_raw,
        input  uart_rxd, rst_n_out, reset_cause, break_active
    );

    modport slave (
        input  key_n, uart_rxd_raw,
        output uart_rxd, rst_n_out, reset_cause, break_active
    );
endinterface

`default_nettype wire

// File: rtl/apple1_sync_debounce.sv
// Multi-flop synchronizer followed by a stable-count filter; idles high (released).
`default_nettype none

module apple1_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din_i,
    output logic      stable_o
);
    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q, stable_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (w_sync != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = w_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
endmodule

`default_nettype wire

// File: rtl/apple1_reset_ctrl.sv
// Apple-1 reset sequencer: power-on, debounced button and UART-break resets,
// each stretched to at least HOLD_CYCLES, plus a synchronized RXD for the core.
`default_nettype none

module apple1_reset_ctrl
    import apple1_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 1024,
    parameter int BREAK_CYCLES    = 6250000,
    parameter int BREAK_EN        = 1
) (
    input  wire logic           clk25,
    input  wire logic           rst,
    apple1_reset_ctrl_if.slave  bus
);
    localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int              BRK_W     = $clog2(BREAK_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BRK_W-1:0]  BRK_MAX   = BRK_W'(BREAK_CYCLES);

    logic                   key_stable;
    logic [SYNC_STAGES-1:0] rxd_sync_q;
    logic                   rxd_sync;
    logic [BRK_W-1:0]       brk_q, brk_d;
    logic                   break_active;
    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [1:0]             cause_q, cause_d;
    logic                   rst_n_q;

    apple1_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk      (clk25),
        .rst      (rst),
        .din_i    (bus.key_n),
        .stable_o (key_stable)
    );

    assign rxd_sync     = rxd_sync_q[SYNC_STAGES-1];
    assign break_active = (brk_q == BRK_MAX) && (BREAK_EN != 0);

    // Saturating low-time counter; any high sample ends the break.
    always_comb begin
        brk_d = '0;
        if (!rxd_sync) begin
            brk_d = (brk_q == BRK_MAX) ? brk_q : brk_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (key_stable && !break_active) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!key_stable) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_KEY;
                end else if (break_active) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_BREAK;
                end
            end
            default: begin
                state_d = ST_HOLD;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            rxd_sync_q <= '1;
            brk_q      <= '0;
            state_q    <= ST_HOLD;
            hold_q     <= '0;
            cause_q    <= CAUSE_POR;
            rst_n_q    <= 1'b0;
        end else begin
            rxd_sync_q <= {rxd_sync_q[SYNC_STAGES-2:0], bus.uart_rxd_raw};
            brk_q      <= brk_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            cause_q    <= cause_d;
            rst_n_q    <= (state_d == ST_RUN);
        end
    end

    assign bus.uart_rxd     = rxd_sync;
    assign bus.rst_n_out    = rst_n_q;
    assign bus.reset_cause  = cause_q;
    assign bus.break_active = break_active;
endmodule

`default_nettype wire

// File: tb/tb_apple1_reset_ctrl.sv
// Directed scoreboard bench: expectations are queued with their due cycle and checked as time advances.
`default_nettype none

module tb_apple1_reset_ctrl;
    localparam int S_RSTN    = 0;
    localparam int S_CAUSE   = 1;
    localparam int S_BRK     = 2;
    localparam int S_RXD     = 3;
    localparam int S_HOLDQ   = 4;
    localparam int S_NB_RSTN = 5;
    localparam int S_NB_BRK  = 6;
    localparam int S_NB_RXD  = 7;

    logic clk25 = 1'b0;
    logic rst;
    always #5 clk25 = ~clk25;

    apple1_reset_ctrl_if bus ();
    apple1_reset_ctrl_if bus_nb ();

    apple1_reset_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(16),
        .BREAK_CYCLES(40), .BREAK_EN(1)
    ) dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus)
    );

    apple1_reset_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(16),
        .BREAK_CYCLES(40), .BREAK_EN(0)
    ) dut_nb (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus_nb)
    );

    int    q_cyc[$];
    int    q_sig[$];
    int    q_val[$];
    string q_tag[$];
    int    cyc     = 0;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    function automatic logic [31:0] observe(int sig);
        case (sig)
            S_RSTN:    return 32'(bus.rst_n_out);
            S_CAUSE:   return 32'(bus.reset_cause);
            S_BRK:     return 32'(bus.break_active);
            S_RXD:     return 32'(bus.uart_rxd);
            S_HOLDQ:   return 32'(dut.hold_q);
            S_NB_RSTN: return 32'(bus_nb.rst_n_out);
            S_NB_BRK:  return 32'(bus_nb.break_active);
            S_NB_RXD:  return 32'(bus_nb.uart_rxd);
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic exp_at(input int d, input int sig, input int val, input string tag);
        q_cyc.push_back(cyc + d);
        q_sig.push_back(sig);
        q_val.push_back(val);
        q_tag.push_back(tag);
    endtask

    task automatic check_due();
        int i;
        logic [31:0] obs;
        logic [31:0] expv;
        i = 0;
        while (i < q_cyc.size()) begin
            if (q_cyc[i] == cyc) begin
                obs  = observe(q_sig[i]);
                expv = 32'(q_val[i]);
                n_checks++;
                assert (obs === expv) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL %s at cycle %0d: observed %0d expected %0d", q_tag[i], cyc, obs, expv);
                end
                q_cyc.delete(i);
                q_sig.delete(i);
                q_val.delete(i);
                q_tag.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk25);
            #1;
            cyc++;
            check_due();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.key_n = 1'b1;
        bus.uart_rxd_raw = 1'b1;
        bus_nb.key_n = 1'b1;
        bus_nb.uart_rxd_raw = 1'b1;

        // reset state
        exp_at(1, S_RSTN, 0, "rst_rstn");
        exp_at(1, S_CAUSE, 0, "rst_cause");
        exp_at(1, S_BRK, 0, "rst_brk");
        exp_at(1, S_RXD, 1, "rst_rxd");
        exp_at(1, S_HOLDQ, 0, "rst_holdq");
        step(3);

        // power-up hold
        rst = 1'b0;
        exp_at(16, S_RSTN, 0, "por_low16");
        exp_at(17, S_RSTN, 1, "por_rise17");
        exp_at(17, S_CAUSE, 0, "por_cause");
        exp_at(17, S_NB_RSTN, 1, "nb_por_rise17");
        step(20);

        // bouncing key never resets
        exp_at(9, S_RSTN, 1, "bounce_a");
        exp_at(21, S_RSTN, 1, "bounce_b");
        exp_at(33, S_RSTN, 1, "bounce_c");
        for (int k = 0; k < 10; k++) begin
            bus.key_n = ~bus.key_n;
            step(3);
        end
        step(6);

        // clean press, held, then released
        bus.key_n = 1'b0;
        exp_at(10, S_RSTN, 1, "press_pre");
        exp_at(11, S_RSTN, 0, "press_fall");
        exp_at(11, S_CAUSE, 1, "press_cause");
        exp_at(40, S_RSTN, 0, "press_held");
        step(40);
        bus.key_n = 1'b1;
        exp_at(10, S_RSTN, 0, "release_pre");
        exp_at(11, S_RSTN, 1, "release_rise");
        step(15);

        // 39-cycle low is not a break
        bus.uart_rxd_raw = 1'b0;
        exp_at(1, S_RXD, 1, "rxd_lat1");
        exp_at(2, S_RXD, 0, "rxd_lat2");
        exp_at(41, S_BRK, 0, "short_brk");
        exp_at(45, S_RSTN, 1, "short_norst");
        step(39);
        bus.uart_rxd_raw = 1'b1;
        step(8);

        // 45-cycle low is a break
        bus.uart_rxd_raw = 1'b0;
        exp_at(41, S_BRK, 0, "brk_pre");
        exp_at(42, S_BRK, 1, "brk_rise");
        exp_at(42, S_RSTN, 1, "brk_rstn_pre");
        exp_at(43, S_RSTN, 0, "brk_fall");
        exp_at(43, S_CAUSE, 2, "brk_cause");
        exp_at(47, S_BRK, 1, "brk_hold");
        exp_at(48, S_BRK, 0, "brk_clear");
        exp_at(59, S_RSTN, 0, "brk_wait");
        exp_at(60, S_RSTN, 1, "brk_recover");
        step(45);
        bus.uart_rxd_raw = 1'b1;
        step(20);

        // press and break land together: button wins
        bus.uart_rxd_raw = 1'b0;
        step(32);
        bus.key_n = 1'b0;
        exp_at(10, S_RSTN, 1, "sim_pre");
        exp_at(10, S_BRK, 1, "sim_brk");
        exp_at(11, S_RSTN, 0, "sim_fall");
        exp_at(11, S_CAUSE, 1, "sim_cause");
        exp_at(28, S_RSTN, 1, "sim_recover");
        step(15);
        bus.key_n = 1'b1;
        bus.uart_rxd_raw = 1'b1;
        step(30);

        // rst during RUN
        rst = 1'b1;
        exp_at(1, S_RSTN, 0, "runrst_rstn");
        exp_at(1, S_CAUSE, 0, "runrst_cause");
        exp_at(1, S_HOLDQ, 0, "runrst_holdq");
        step(1);
        rst = 1'b0;
        exp_at(16, S_RSTN, 0, "runrst_low16");
        exp_at(17, S_RSTN, 1, "runrst_rise17");
        step(20);

        // rst during HOLD with hold counter at 7
        bus.key_n = 1'b0;
        exp_at(11, S_CAUSE, 1, "hold_cause");
        exp_at(18, S_HOLDQ, 7, "hold_cnt7");
        exp_at(19, S_RSTN, 0, "holdrst_rstn");
        exp_at(19, S_CAUSE, 0, "holdrst_cause");
        exp_at(19, S_HOLDQ, 0, "holdrst_cnt");
        exp_at(35, S_RSTN, 0, "holdrst_low16");
        exp_at(36, S_RSTN, 1, "holdrst_rise17");
        step(12);
        bus.key_n = 1'b1;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);

        // break detection disabled
        bus_nb.uart_rxd_raw = 1'b0;
        exp_at(1, S_NB_RXD, 1, "nb_rxd_lat1");
        exp_at(2, S_NB_RXD, 0, "nb_rxd_lat2");
        exp_at(50, S_NB_BRK, 0, "nb_brk50");
        exp_at(100, S_NB_BRK, 0, "nb_brk100");
        exp_at(100, S_NB_RSTN, 1, "nb_rstn100");
        exp_at(100, S_RSTN, 1, "main_unaffected");
        step(100);
        bus_nb.uart_rxd_raw = 1'b1;
        exp_at(1, S_NB_RXD, 0, "nb_rxd_rel1");
        exp_at(2, S_NB_RXD, 1, "nb_rxd_rel2");
        step(4);

        n_checks++;
        assert (q_cyc.size() == 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", q_cyc.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
